// File: rtl/display_scan_if.sv
// Bus between the display scan controller and the rest of the board.
// slave: the scan controller. master: whoever supplies display data and
// consumes the anode select and segment data.
interface display_scan_if;
  logic        enable;
  logic [31:0] digits;
  logic [7:0]  dp_mask;
  logic [7:0]  digit_en;
  logic [2:0]  sel;
  logic [3:0]  nibble;
  logic        dp;
  logic        blank;
  logic        frame_tick;

  modport slave (
    input  enable, digits, dp_mask, digit_en,
    output sel, nibble, dp, blank, frame_tick
  );

  modport master (
    output enable, digits, dp_mask, digit_en,
    input  sel, nibble, dp, blank, frame_tick
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// Each digit slot is DIV cycles long: BLANK_CYCLES of guard (anodes off),
// then the digit is shown. Display data is snapshotted once per frame so a
// frame never mixes old and new digits.
module display_scan_ctrl #(
  parameter int DIV          = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           rst,
  display_scan_if.slave  bus
);

  localparam int CNT_W = $clog2(DIV);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GUARD = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIV - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       sel;
  logic             frame_tick;
  logic [31:0]      snap_digits;
  logic [7:0]       snap_dp;
  logic [7:0]       snap_en;

  // Scan sequencing, slot counting and per-frame snapshot of display data.
  // Dropping enable wins over every other transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sel         <= '0;
      frame_tick  <= 1'b0;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_en     <= '0;
    end else begin
      frame_tick <= 1'b0;
      if (!bus.enable) begin
        state <= IDLE;
        cnt   <= '0;
        sel   <= '0;
      end else begin
        case (state)
          IDLE: begin
            // Start of scanning: no frame_tick on this first frame.
            state       <= GUARD;
            cnt         <= '0;
            sel         <= '0;
            snap_digits <= bus.digits;
            snap_dp     <= bus.dp_mask;
            snap_en     <= bus.digit_en;
          end
          GUARD: begin
            cnt <= cnt + 1'b1;
            if (cnt == GUARD_LAST) begin
              state <= SHOW;
            end
          end
          SHOW: begin
            if (cnt == SLOT_LAST) begin
              state <= GUARD;
              cnt   <= '0;
              sel   <= sel + 3'd1;
              if (sel == 3'd7) begin
                // Frame boundary: take a fresh snapshot for the new frame.
                frame_tick  <= 1'b1;
                snap_digits <= bus.digits;
                snap_dp     <= bus.dp_mask;
                snap_en     <= bus.digit_en;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            sel   <= '0;
          end
        endcase
      end
    end
  end

  // Outputs are registers or register-indexed muxes of the snapshot, so they
  // never follow the live digit inputs and stay glitch-free.
  assign bus.sel        = sel;
  assign bus.nibble     = snap_digits[{sel, 2'b00} +: 4];
  assign bus.dp         = snap_dp[sel];
  assign bus.blank      = (state != SHOW) || !snap_en[sel];
  assign bus.frame_tick = frame_tick;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with DIV = 4, BLANK_CYCLES = 1.
module tb_display_scan_ctrl;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  display_scan_if bus ();

  display_scan_ctrl #(.DIV(4), .BLANK_CYCLES(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs for cycle c (0..3) of slot s given the frame snapshot.
  task automatic chk(input int s, input int c, input logic [31:0] ed,
                     input logic [7:0] edp, input logic [7:0] een, input bit first);
    logic [31:0] exp_nib;
    logic        exp_blank;
    logic        exp_ft;
    exp_nib   = (ed >> (4 * s)) & 32'hF;
    exp_blank = (c == 0) || !een[s];
    exp_ft    = (s == 0) && (c == 0) && !first;
    check($sformatf("sel_s%0d_c%0d", s, c),    32'(bus.sel),        32'(s));
    check($sformatf("blank_s%0d_c%0d", s, c),  32'(bus.blank),      32'(exp_blank));
    check($sformatf("nibble_s%0d_c%0d", s, c), 32'(bus.nibble),     exp_nib);
    check($sformatf("dp_s%0d_c%0d", s, c),     32'(bus.dp),         32'(edp[s]));
    check($sformatf("ftick_s%0d_c%0d", s, c),  32'(bus.frame_tick), 32'(exp_ft));
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_sel"},    32'(bus.sel),        32'd0);
    check({tag, "_blank"},  32'(bus.blank),      32'd1);
    check({tag, "_ftick"},  32'(bus.frame_tick), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst          = 1'b1;
    bus.enable   = 1'b0;
    bus.digits   = 32'h0;
    bus.dp_mask  = 8'h0;
    bus.digit_en = 8'h0;

    // Reset held for 3 cycles with enable low.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle($sformatf("rst%0d", i));
      check($sformatf("rst%0d_nibble", i), 32'(bus.nibble), 32'd0);
      check($sformatf("rst%0d_dp", i),     32'(bus.dp),     32'd0);
    end
    rst = 1'b0;
    tick();
    chk_idle("post_rst");

    // Frame 1: full scan.
    bus.digits   = 32'h7654_3210;
    bus.dp_mask  = 8'h04;
    bus.digit_en = 8'hFF;
    bus.enable   = 1'b1;
    tick();
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 4; c++) begin
        chk(s, c, 32'h7654_3210, 8'h04, 8'hFF, 1'b1);
        tick();
      end
    end

    // Frame 2: inputs change mid-frame, must not show until the next frame.
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 4; c++) begin
        chk(s, c, 32'h7654_3210, 8'h04, 8'hFF, 1'b0);
        if (s == 3 && c == 1) begin
          bus.digits   = 32'hFFFF_FFFF;
          bus.digit_en = 8'h0F;
        end
        tick();
      end
    end

    // Frame 3: new snapshot, digits 4..7 blanked for their whole slot.
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 4; c++) begin
        chk(s, c, 32'hFFFF_FFFF, 8'h04, 8'h0F, 1'b0);
        if (s == 6 && c == 0) bus.digit_en = 8'hFF;
        tick();
      end
    end

    // Frame 4: disable during SHOW of sel = 5.
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 4; c++) begin
        chk(s, c, 32'hFFFF_FFFF, 8'h04, 8'hFF, 1'b0);
        tick();
      end
    end
    chk(5, 0, 32'hFFFF_FFFF, 8'h04, 8'hFF, 1'b0);
    tick();
    chk(5, 1, 32'hFFFF_FFFF, 8'h04, 8'hFF, 1'b0);
    bus.enable = 1'b0;
    tick();
    chk_idle("disable0");
    tick();
    chk_idle("disable1");

    // Re-enable: restart at sel = 0 with one guard cycle and no frame_tick.
    bus.enable = 1'b1;
    tick();
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < 4; c++) begin
        chk(s, c, 32'hFFFF_FFFF, 8'h04, 8'hFF, 1'b1);
        tick();
      end
    end
    chk(6, 0, 32'hFFFF_FFFF, 8'h04, 8'hFF, 1'b1);
    tick();
    chk(6, 1, 32'hFFFF_FFFF, 8'h04, 8'hFF, 1'b1);

    // Asynchronous reset between edges during SHOW of sel = 6.
    #2 rst = 1'b1;
    #1;
    chk_idle("async_rst");
    check("async_rst_nibble", 32'(bus.nibble), 32'd0);
    check("async_rst_dp",     32'(bus.dp),     32'd0);
    tick();
    rst = 1'b0;
    bus.enable = 1'b0;
    tick();
    chk_idle("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for the 8-digit seven-segment display of the reaction-timer board. It walks a 3-bit digit select through digits 0..7 at a programmable refresh rate and drives the select into the existing 3-to-8 anode decoder. It presents the matching BCD nibble and decimal point for the segment encoder. It inserts a blanking guard at every digit change to suppress ghosting, and it snapshots the display data once per frame so a digit never tears mid-frame.

## Interface
Parameters:
- DIV, 100000: clock cycles per digit slot; legal range DIV >= BLANK_CYCLES + 2.
- BLANK_CYCLES, 1000: guard cycles at the start of each slot, during which `blank` = 1; legal range >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  scan enable; 0 = display off
- digits  in  32  eight BCD nibbles; digit k = digits[4k+3:4k]
- dp_mask  in  8  decimal point per digit; bit k belongs to digit k
- digit_en  in  8  per-digit enable; 0 = digit blanked for its whole slot (leading-zero suppression)
- sel  out  3  digit select; feeds the anode decoder `data` input
- nibble  out  4  snapshot nibble of the digit at `sel`
- dp  out  1  snapshot dp_mask bit of the digit at `sel`
- blank  out  1  1 = all anodes must be forced off by the top level
- frame_tick  out  1  one-cycle pulse at the start of each new frame

## Operation
- State machine with states IDLE, GUARD and SHOW, plus slot counter `cnt` of width $clog2(DIV).
- Reset (async, any time): state = IDLE, cnt = 0, sel = 0, snapshot registers = 0, nibble = 0, dp = 0, blank = 1, frame_tick = 0.
- IDLE:
  - Outputs: blank = 1, sel = 0.
  - If enable = 1: next state is GUARD, cnt = 0, sel = 0, and the snapshot loads from digits, dp_mask and digit_en.
  - frame_tick does not pulse on this start.
- GUARD:
  - blank = 1 and cnt increments each cycle.
  - When cnt == BLANK_CYCLES-1, next state is SHOW and cnt continues counting.
- SHOW:
  - blank = ~snap_en[sel].
  - When cnt == DIV-1, next state is GUARD, cnt = 0, and sel = sel+1 mod 8.
  - On the 7 -> 0 wrap only: the snapshot reloads in the same edge, and frame_tick = 1 for the following cycle.
- enable = 0 sampled in any state: next state is IDLE with cnt = 0, sel = 0 and blank = 1. This takes priority over every other transition.
- nibble and dp are muxed from the snapshot registers by `sel` only. They never depend combinationally on the `digits` input.
- Changes to digits, dp_mask or digit_en mid-frame have no visible effect until the next frame reload.
- No arithmetic on digit data; nibble values 10-15 pass through unchanged.

## Timing
- Every output is a register or a mux of registers indexed by a register, so outputs are glitch-free.
- Start-up: enable rises and is sampled at edge E.
  - E+1: GUARD, sel = 0.
  - E+1+BLANK_CYCLES: SHOW (blank falls if snap_en[0] = 1).
- Slot length is exactly DIV cycles: BLANK_CYCLES of guard followed by DIV-BLANK_CYCLES of show. Frame length is 8*DIV cycles.
- sel changes only on the edge where GUARD begins, so the anode select is stable whenever blank = 0.
- frame_tick occurs once every 8*DIV cycles and coincides with the first GUARD cycle of sel = 0.
- Reset asserted mid-frame: outputs reach their reset values immediately (asynchronously). After rst is released, the block restarts from IDLE.

## Test plan
Test configuration: DIV = 4, BLANK_CYCLES = 1.
- Reset then hold: rst = 1 for 3 cycles, enable = 0 -> sel = 0, blank = 1, nibble = 0, dp = 0, frame_tick = 0 throughout.
- Full scan: digits = 32'h7654_3210, dp_mask = 8'h04, digit_en = 8'hFF, raise enable ->
  - sel steps 0..7 every 4 cycles, each slot showing blank = 1 for 1 cycle then 0 for 3.
  - nibble equals sel in every SHOW cycle; dp = 1 only while sel = 2.
  - frame_tick pulses 32 cycles after the first GUARD cycle, and sel wraps to 0 on that cycle.
- Snapshot: change digits to 32'hFFFF_FFFF while sel = 3 -> nibble stays equal to sel through sel = 7, and reads 4'hF from the next frame (sel = 0).
- Blanking mask: digit_en = 8'h0F -> blank = 1 during the entire slots for sel = 4..7, with normal guard/show behaviour for sel = 0..3.
- Disable mid-slot: drop enable during SHOW with sel = 5 -> next cycle sel = 0 and blank = 1. Re-enabling restarts at sel = 0 after 1 guard cycle with no frame_tick.
- Async reset mid-frame: assert rst between clock edges during SHOW with sel = 6 -> blank = 1 and sel = 0 before the next clock edge.
